// File: rtl/mem_access_pkg.sv
// Shared MEM-stage definitions: widths, FSM encoding
// and the control pattern written into WB for a bubble.
package mem_access_pkg;
  localparam int WORD   = 32;
  localparam int RWIDTH = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  // {MemtoReg, RegWrite}
  localparam logic [1:0] WB_CTRL_BUBBLE = 2'b00;
endpackage

// File: rtl/mem_access_stage_mem_wb.sv
// MEM/WB register bank: loads MEM fields or a bubble.
// Read data is only replaced by a completed load.
module mem_wb_reg
  import mem_access_pkg::*;
#(
  parameter int word   = WORD,
  parameter int rwidth = RWIDTH
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              load,
  input  logic              bubble,
  input  logic              rdata_en,
  input  logic              memtoreg_i,
  input  logic              regwrite_i,
  input  logic [word-1:0]   rdata_i,
  input  logic [word-1:0]   alu_i,
  input  logic [rwidth-1:0] rd_i,
  output logic              WB_MemtoReg,
  output logic              WB_RegWrite,
  output logic [word-1:0]   WB_Read_data,
  output logic [word-1:0]   WB_ALU_result,
  output logic [rwidth-1:0] WB_MUX8_out
);
  logic [1:0]        ctrl_q, ctrl_d;
  logic [word-1:0]   rdata_q, rdata_d;
  logic [word-1:0]   alu_q, alu_d;
  logic [rwidth-1:0] rd_q, rd_d;

  always_comb begin
    ctrl_d  = ctrl_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    if (bubble) begin
      ctrl_d = WB_CTRL_BUBBLE;
      alu_d  = '0;
      rd_d   = '0;
    end else if (load) begin
      ctrl_d = {memtoreg_i, regwrite_i};
      alu_d  = alu_i;
      rd_d   = rd_i;
      if (rdata_en) rdata_d = rdata_i;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ctrl_q  <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
    end
  end

  assign WB_MemtoReg   = ctrl_q[1];
  assign WB_RegWrite   = ctrl_q[0];
  assign WB_Read_data  = rdata_q;
  assign WB_ALU_result = alu_q;
  assign WB_MUX8_out   = rd_q;
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory handshake FSM with
// alignment check, ack timeout and MEM/WB register.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int word    = WORD,
  parameter int rwidth  = RWIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic              MEM_MemtoReg,
  input  logic              MEM_RegWrite,
  input  logic [word-1:0]   MEM_ALU_result,
  input  logic [word-1:0]   MEM_MUX6_out,
  input  logic [rwidth-1:0] MEM_MUX8_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [word-1:0]   dmem_addr,
  output logic [word-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [word-1:0]   dmem_rdata,
  output logic              Stall,
  output logic              MemFault,
  output logic              WB_MemtoReg,
  output logic              WB_RegWrite,
  output logic [word-1:0]   WB_Read_data,
  output logic [word-1:0]   WB_ALU_result,
  output logic [rwidth-1:0] WB_MUX8_out
);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fault_q, fault_d;
  logic       memop, bad, in_req;
  logic       load, rdata_en;

  assign memop  = MEM_MemRead | MEM_MemWrite;
  assign bad    = (MEM_ALU_result[1:0] != 2'b00)
                | (MEM_MemRead & MEM_MemWrite);
  assign in_req = (state_q == S_REQ);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fault_d  = 1'b0;
    Stall    = 1'b0;
    load     = 1'b0;
    rdata_en = 1'b0;
    unique case (1'b1)
      !in_req && memop && !bad: begin
        Stall   = 1'b1;
        state_d = S_REQ;
        cnt_d   = '0;
      end
      !in_req && memop && bad: fault_d = 1'b1;
      !in_req && !memop:       load    = 1'b1;
      in_req && dmem_ack: begin
        load     = 1'b1;
        rdata_en = MEM_MemRead;
        state_d  = S_IDLE;
      end
      in_req && !dmem_ack && (cnt_q == CNT_LAST): begin
        fault_d = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        Stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Request lines decode registered state; EX/MEM is
  // held by Stall, so address and data stay stable.
  assign dmem_req   = in_req;
  assign dmem_we    = in_req & MEM_MemWrite;
  assign dmem_addr  = MEM_ALU_result;
  assign dmem_wdata = MEM_MUX6_out;
  assign MemFault   = fault_q;

  mem_wb_reg #(
    .word   (word),
    .rwidth (rwidth)
  ) u_mem_wb (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .load          (load),
    .bubble        (!load),
    .rdata_en      (rdata_en),
    .memtoreg_i    (MEM_MemtoReg),
    .regwrite_i    (MEM_RegWrite),
    .rdata_i       (dmem_rdata),
    .alu_i         (MEM_ALU_result),
    .rd_i          (MEM_MUX8_out),
    .WB_MemtoReg   (WB_MemtoReg),
    .WB_RegWrite   (WB_RegWrite),
    .WB_Read_data  (WB_Read_data),
    .WB_ALU_result (WB_ALU_result),
    .WB_MUX8_out   (WB_MUX8_out)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage
// against an instruction-level outcome model.
module tb_mem_access_stage;
  localparam int TO = 4;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        MEM_MemRead = 1'b0, MEM_MemWrite = 1'b0;
  logic        MEM_MemtoReg = 1'b0, MEM_RegWrite = 1'b0;
  logic [31:0] MEM_ALU_result = '0, MEM_MUX6_out = '0;
  logic [4:0]  MEM_MUX8_out = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        Stall, MemFault;
  logic        WB_MemtoReg, WB_RegWrite;
  logic [31:0] WB_Read_data, WB_ALU_result;
  logic [4:0]  WB_MUX8_out;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  mem_access_stage #(.word(32), .rwidth(5), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite),
    .MEM_ALU_result(MEM_ALU_result), .MEM_MUX6_out(MEM_MUX6_out),
    .MEM_MUX8_out(MEM_MUX8_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .Stall(Stall), .MemFault(MemFault),
    .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite),
    .WB_Read_data(WB_Read_data), .WB_ALU_result(WB_ALU_result),
    .WB_MUX8_out(WB_MUX8_out)
  );

  // One instruction through MEM. ack_delay = number of
  // REQ cycles without ack before ack (>= TO: never).
  task automatic run_op(
    input string       name,
    input logic        rd, wr, m2r, rw,
    input logic [31:0] addr, wdata, rdat,
    input logic [4:0]  rdst,
    input int          ack_delay
  );
    logic is_mem, is_bad, ok, bub;
    int   exp_stall, stalls, reqc, cyc;
    logic done;
    is_mem = rd | wr;
    is_bad = is_mem && ((addr % 4) != 0 || (rd && wr));
    ok     = is_mem && !is_bad && ack_delay < TO;
    bub    = is_mem && !ok;
    exp_stall = (!is_mem || is_bad) ? 0
              : (ok ? 1 + ack_delay : TO);
    MEM_MemRead = rd; MEM_MemWrite = wr;
    MEM_MemtoReg = m2r; MEM_RegWrite = rw;
    MEM_ALU_result = addr; MEM_MUX6_out = wdata;
    MEM_MUX8_out = rdst; dmem_rdata = rdat;
    stalls = 0; reqc = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      if (dmem_req) dmem_ack = (reqc == ack_delay);
      else dmem_ack = 1'($urandom_range(0, 1));
      #1;
      if (cyc == 0) begin
        checks++;
        if (dmem_req !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_req got %b want 0", name, dmem_req);
        end
      end
      if (dmem_req === 1'b1) begin
        checks++;
        if (dmem_we !== wr || dmem_addr !== addr
            || dmem_wdata !== wdata) begin
          errors++;
          $display("FAIL %s req_bus got we=%b a=%h d=%h want we=%b a=%h d=%h",
                   name, dmem_we, dmem_addr, dmem_wdata, wr, addr, wdata);
        end
        reqc++;
      end
      if (Stall === 1'b1) stalls++;
      else done = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      cyc++;
      if (!done) begin
        checks++;
        if (WB_RegWrite !== 1'b0 || MemFault !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_bubble got rw=%b flt=%b want 0 0",
                   name, WB_RegWrite, MemFault);
        end
      end
    end
    dmem_ack = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout got stall stuck want release", name);
    end
    checks++;
    if (stalls != exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, exp_stall);
    end
    checks++;
    if (MemFault !== bub) begin
      errors++;
      $display("FAIL %s memfault got %b want %b", name, MemFault, bub);
    end
    checks++;
    if (bub) begin
      if (WB_RegWrite !== 1'b0 || WB_MemtoReg !== 1'b0) begin
        errors++;
        $display("FAIL %s wb_bubble got rw=%b m2r=%b want 0 0",
                 name, WB_RegWrite, WB_MemtoReg);
      end
    end else if (WB_RegWrite !== rw || WB_MemtoReg !== m2r
                 || WB_ALU_result !== addr || WB_MUX8_out !== rdst) begin
      errors++;
      $display("FAIL %s wb_fields got rw=%b m2r=%b alu=%h rd=%0d want %b %b %h %0d",
               name, WB_RegWrite, WB_MemtoReg, WB_ALU_result, WB_MUX8_out,
               rw, m2r, addr, rdst);
    end
    if (ok && rd) begin
      checks++;
      if (WB_Read_data !== rdat) begin
        errors++;
        $display("FAIL %s wb_rdata got %h want %h", name, WB_Read_data, rdat);
      end
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || Stall !== 1'b0 || MemFault !== 1'b0
        || WB_RegWrite !== 1'b0 || WB_MemtoReg !== 1'b0
        || WB_Read_data !== 32'h0 || WB_ALU_result !== 32'h0
        || WB_MUX8_out !== 5'h0) begin
      errors++;
      $display("FAIL reset got req=%b st=%b flt=%b rw=%b alu=%h want all 0",
               dmem_req, Stall, MemFault, WB_RegWrite, WB_ALU_result);
    end
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op("alu_op", 0, 0, 0, 1, 32'h0000_1234, 32'h0, 32'h0, 5'd3, 0);
    run_op("load_ack3", 1, 0, 1, 1, 32'h100, 32'h0, 32'hDEADBEEF, 5'd7, 3);
    run_op("store_ack0", 0, 1, 0, 0, 32'h104, 32'hA5A5A5A5, 32'h0, 5'd0, 0);
    run_op("misaligned", 1, 0, 1, 1, 32'h102, 32'h0, 32'h0, 5'd9, 0);
    run_op("rd_and_wr", 1, 1, 1, 1, 32'h200, 32'h1, 32'h0, 5'd2, 0);
    run_op("load_timeout", 1, 0, 1, 1, 32'h108, 32'h0, 32'h55, 5'd4, 255);
    run_op("after_fault", 0, 0, 0, 1, 32'h0000_0042, 32'h0, 32'h0, 5'd5, 0);
    run_op("load_ack_last", 1, 0, 1, 1, 32'h10C, 32'h0, 32'h1234_5678, 5'd6, TO - 1);
  endtask

  task automatic test_reset_mid_req();
    run_op("pre_reset", 0, 0, 0, 1, 32'h77, 32'h0, 32'h0, 5'd8, 0);
    MEM_MemRead = 1; MEM_MemWrite = 0; MEM_MemtoReg = 1; MEM_RegWrite = 1;
    MEM_ALU_result = 32'h300; MEM_MUX8_out = 5'd11; dmem_ack = 0;
    repeat (2) @(negedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || MemFault !== 1'b0 || WB_RegWrite !== 1'b0
        || WB_MemtoReg !== 1'b0 || WB_ALU_result !== 32'h0
        || WB_MUX8_out !== 5'h0 || WB_Read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got req=%b rw=%b alu=%h rd=%0d want 0",
               dmem_req, WB_RegWrite, WB_ALU_result, WB_MUX8_out);
    end
    MEM_MemRead = 0; MEM_MemtoReg = 0; MEM_RegWrite = 0;
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    run_op("post_reset_load", 1, 0, 1, 1, 32'h300, 32'h0, 32'hCAFE_F00D, 5'd11, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic        r, w;
      logic [31:0] a;
      int          k;
      k = int'($urandom_range(0, 9));
      r = (k < 4) || (k == 9);
      w = (k >= 4 && k < 7) || (k == 9);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_op("random", r, w, 1'($urandom), 1'($urandom), a,
             $urandom, $urandom, 5'($urandom),
             int'($urandom_range(0, TO + 1)));
    end
  endtask

  initial begin
    test_reset();
    @(negedge Clock);
    test_directed();
    test_reset_mid_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter word, default 32, data/address width.
REQ-002 Parameter rwidth, default 5, register-index width.
REQ-003 Parameter TIMEOUT, default 16, maximum REQ-state cycles awaiting dmem_ack (range 1..255).
REQ-004 Clock  in  1  single clock; all state updates on posedge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite  in  1 each  control from EX/MEM register.
REQ-007 MEM_ALU_result  in  word  memory address / ALU result.
REQ-008 MEM_MUX6_out  in  word  store data.
REQ-009 MEM_MUX8_out  in  rwidth  destination register.
REQ-010 dmem_req, dmem_we  out  1 each  data-memory request / write-enable.
REQ-011 dmem_addr, dmem_wdata  out  word each  memory address / write data.
REQ-012 dmem_ack  in  1  memory completion, sampled only in REQ.
REQ-013 dmem_rdata  in  word  load data, valid when dmem_ack=1.
REQ-014 Stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM registers.
REQ-015 MemFault  out  1  one-cycle fault pulse.
REQ-016 WB_MemtoReg, WB_RegWrite  out  1 each  registered control to WB.
REQ-017 WB_Read_data, WB_ALU_result  out  word each  registered load data / ALU result.
REQ-018 WB_MUX8_out  out  rwidth  registered destination register.

Function
REQ-019 memop = MEM_MemRead | MEM_MemWrite; aligned = (MEM_ALU_result[1:0] == 0); bad = ~aligned | (MEM_MemRead & MEM_MemWrite).
REQ-020 The FSM SHALL have two states: IDLE and REQ.
REQ-021 IDLE, memop & ~bad: Stall=1, dmem_req=0; next state REQ; timeout counter cleared to 0.
REQ-022 IDLE, memop & bad: no request issued; Stall=0; MemFault=1 next cycle; WB registers load a bubble.
REQ-023 IDLE, ~memop: Stall=0; WB registers load MEM_* fields, with WB_Read_data holding its previous value.
REQ-024 REQ: dmem_req=1, dmem_we=MEM_MemWrite, dmem_addr=MEM_ALU_result, dmem_wdata=MEM_MUX6_out; all four SHALL be held stable until ack or timeout.
REQ-025 REQ, dmem_ack=1: Stall=0 combinationally in the same cycle; WB registers load MEM_* fields and WB_Read_data<=dmem_rdata (reads only); next state IDLE.
REQ-026 REQ, dmem_ack=0, counter = TIMEOUT-1: Stall=0; MemFault=1 next cycle; WB registers load a bubble; next state IDLE.
REQ-027 REQ, dmem_ack=0, counter < TIMEOUT-1: Stall=1; counter increments.
REQ-028 Stall = (IDLE & memop & ~bad) | (REQ & ~dmem_ack & counter != TIMEOUT-1).
REQ-029 While Stall=1, WB registers SHALL load a bubble, so the instruction writes back once.
REQ-030 Bubble: WB_RegWrite=0 and WB_MemtoReg=0; other WB fields are don't-care but SHALL be deterministic.
REQ-031 Minimum memory-op latency SHALL be 2 cycles (ack in first REQ cycle); non-memory ops SHALL have 1-cycle latency with no stall.
REQ-032 dmem_ack outside REQ SHALL be ignored.
REQ-033 dmem_req SHALL be driven from registered state only.

Reset
REQ-034 Reset_n low SHALL force, asynchronously: state IDLE, counter 0, dmem_req=0, MemFault=0, all WB_* outputs 0.
REQ-035 Reset asserted during REQ SHALL abandon the access with no WB update; after release, the block SHALL restart in IDLE.

Structure
REQ-036 A shared pipeline package SHALL hold word, rwidth, the FSM state encoding and the bubble constant.
REQ-037 One sub-module, mem_wb_reg, SHALL implement the WB register bank with load and bubble inputs.

Verification
REQ-038 Non-memory op, ALU_result=0x0000_1234, RegWrite=1 -> next cycle WB_ALU_result=0x1234, WB_RegWrite=1, Stall never high.
REQ-039 Load from 0x100, ack after 3 REQ cycles with rdata=0xDEADBEEF -> Stall high 4 cycles, WB_Read_data=0xDEADBEEF, WB_RegWrite pulses once.
REQ-040 Store to 0x104 with data 0xA5A5A5A5, ack in first REQ cycle -> dmem_we=1, dmem_wdata=0xA5A5A5A5, Stall high 1 cycle.
REQ-041 Load from 0x102 -> no dmem_req, MemFault pulse 1 cycle, WB_RegWrite=0.
REQ-042 Load with no ack and TIMEOUT=4 -> Stall high 4 cycles, then MemFault pulse, IDLE, WB_RegWrite=0.
REQ-043 Reset_n dropped in the 2nd REQ cycle -> dmem_req=0 immediately, all WB_* = 0, next op after release completes normally.
